// File: rtl/spi_pkg.sv
// Shared SPI definitions: configuration record, byte width and target FSM states.
package spi_pkg;

  localparam int unsigned SPI_BITS  = 8;
  localparam int unsigned SPI_IDX_W = $clog2(SPI_BITS);

  typedef struct packed {
    logic        msb_first;
    logic        cpol;
    logic        cpha;
    logic [15:0] clk_div;
    logic [7:0]  cs_setup;
  } spi_cfg_t;

  typedef enum logic {
    IDLE,
    ACTIVE
  } tgt_state_e;

  // Wire-order index to byte bit position; MSB-first mirrors the index.
  function automatic logic [SPI_IDX_W-1:0] bit_pos(input logic                 msb_first,
                                                   input logic [SPI_IDX_W-1:0] idx);
    return msb_first ? ~idx : idx;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// N-stage single-bit synchroniser with asynchronous reset to a supplied value.
module spi_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic i_rst_val,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_q <= {STAGES{i_rst_val}};
    end else begin
      r_q <= {r_q[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_q[STAGES-1];

endmodule

// File: rtl/spi_target_physical.sv
// SPI target physical layer: oversampled pins, MOSI deserialiser, MISO serialiser,
// all four CPOL/CPHA modes and both bit orders.
module spi_target_physical
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       ena,
  input  logic       msb_first,
  input  logic       cpol,
  input  logic       cpha,
  input  logic [7:0] data_in,
  output logic       tx_load,
  output logic [7:0] data_out,
  output logic       new_byte,
  output logic       frame_abort,
  output logic       busy,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic       spi_cs_n
);

  localparam int unsigned SETTLE   = SYNC_STAGES + 1;
  localparam int unsigned SETTLE_W = $clog2(SETTLE + 1);

  logic w_sclk_s, w_mosi_s, w_cs_s;

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .nrst(nrst), .i_rst_val(cpol), .i_d(spi_clk), .o_q(w_sclk_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .nrst(nrst), .i_rst_val(1'b0), .i_d(spi_mosi), .o_q(w_mosi_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .nrst(nrst), .i_rst_val(1'b1), .i_d(spi_cs_n), .o_q(w_cs_s)
  );

  tgt_state_e             r_state, w_state_nxt;
  logic                   r_sclk_d, r_cs_d;
  logic [SETTLE_W-1:0]    r_settle_cnt;
  logic [7:0]             r_data_out, w_data_out_nxt;
  logic                   r_new_byte, w_new_byte_nxt;
  logic                   r_tx_load, w_tx_load_nxt;
  logic                   r_abort, w_abort_nxt;
  logic                   r_busy, r_miso_oe, w_active_nxt;
  logic                   r_miso, w_miso_nxt;
  logic [SPI_IDX_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
  logic [SPI_IDX_W-1:0]   r_tx_idx, w_tx_idx_nxt;
  logic [7:0]             r_tx_sr, w_tx_sr_nxt;
  logic [7:0]             r_rx_sr, w_rx_sr_nxt;
  logic [7:0]             w_rx_byte;

  logic w_settled, w_cs_fall, w_cs_rise, w_sclk_edge, w_lead, w_trail, w_sample, w_shift;

  // CS falls are only trusted once the synchronisers hold real pin values,
  // so a frame already running at reset release is ignored until CS rises.
  assign w_settled   = (r_settle_cnt == SETTLE_W'(SETTLE));
  assign w_cs_fall   = w_settled & ~w_cs_s & r_cs_d;
  assign w_cs_rise   = w_cs_s & ~r_cs_d;
  assign w_sclk_edge = w_sclk_s ^ r_sclk_d;
  assign w_lead      = w_sclk_edge & (r_sclk_d == cpol);
  assign w_trail     = w_sclk_edge & (r_sclk_d != cpol);
  assign w_sample    = cpha ? w_trail : w_lead;
  assign w_shift     = cpha ? w_lead : w_trail;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sclk_d     <= cpol;
      r_cs_d       <= 1'b1;
      r_settle_cnt <= '0;
    end else begin
      r_sclk_d <= w_sclk_s;
      r_cs_d   <= w_cs_s;
      if (!w_settled) r_settle_cnt <= r_settle_cnt + SETTLE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= IDLE;
      r_data_out  <= '0;
      r_new_byte  <= 1'b0;
      r_tx_load   <= 1'b0;
      r_abort     <= 1'b0;
      r_busy      <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_miso      <= 1'b0;
      r_bit_cnt   <= '0;
      r_tx_idx    <= '0;
      r_tx_sr     <= '0;
      r_rx_sr     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_data_out  <= w_data_out_nxt;
      r_new_byte  <= w_new_byte_nxt;
      r_tx_load   <= w_tx_load_nxt;
      r_abort     <= w_abort_nxt;
      r_busy      <= w_active_nxt;
      r_miso_oe   <= w_active_nxt;
      r_miso      <= w_miso_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_tx_idx    <= w_tx_idx_nxt;
      r_tx_sr     <= w_tx_sr_nxt;
      r_rx_sr     <= w_rx_sr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_data_out_nxt = r_data_out;
    w_new_byte_nxt = 1'b0;
    w_tx_load_nxt  = 1'b0;
    w_abort_nxt    = 1'b0;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_tx_idx_nxt   = r_tx_idx;
    w_tx_sr_nxt    = r_tx_sr;
    w_rx_sr_nxt    = r_rx_sr;
    w_miso_nxt     = r_miso;
    w_rx_byte      = r_rx_sr;

    case (r_state)
      IDLE: begin
        if (w_cs_fall && ena) begin
          w_state_nxt   = ACTIVE;
          w_tx_sr_nxt   = data_in;
          w_tx_load_nxt = 1'b1;
          w_bit_cnt_nxt = '0;
          w_tx_idx_nxt  = '0;
          w_miso_nxt    = cpha ? 1'b0 : data_in[bit_pos(msb_first, '0)];
        end
      end
      ACTIVE: begin
        // CS rise takes priority over a coincident sample edge.
        if (w_cs_rise) begin
          w_state_nxt = IDLE;
          w_abort_nxt = (r_bit_cnt != '0);
        end else if (w_sample) begin
          w_rx_byte[bit_pos(msb_first, r_bit_cnt)] = w_mosi_s;
          w_rx_sr_nxt   = w_rx_byte;
          w_bit_cnt_nxt = r_bit_cnt + SPI_IDX_W'(1);
          if (r_bit_cnt == SPI_IDX_W'(SPI_BITS - 1)) begin
            w_data_out_nxt = w_rx_byte;
            w_new_byte_nxt = 1'b1;
            w_tx_sr_nxt    = data_in;
            w_tx_load_nxt  = 1'b1;
          end
          if (!cpha) w_miso_nxt = w_tx_sr_nxt[bit_pos(msb_first, r_tx_idx)];
        end else if (w_shift) begin
          // CPHA=1 drives the current index then advances; CPHA=0 advances then drives.
          w_tx_idx_nxt = r_tx_idx + SPI_IDX_W'(1);
          w_miso_nxt   = cpha ? r_tx_sr[bit_pos(msb_first, r_tx_idx)]
                              : r_tx_sr[bit_pos(msb_first, w_tx_idx_nxt)];
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_active_nxt = (w_state_nxt == ACTIVE);
    if (!w_active_nxt) w_miso_nxt = 1'b0;
  end

  assign tx_load     = r_tx_load;
  assign data_out    = r_data_out;
  assign new_byte    = r_new_byte;
  assign frame_abort = r_abort;
  assign busy        = r_busy;
  assign spi_miso    = r_miso;
  assign spi_miso_oe = r_miso_oe;

endmodule

// File: tb/tb_spi_target_physical.sv
// Directed bench for spi_target_physical: a behavioural SPI master drives the pins.
module tb_spi_target_physical;

  localparam int H = 5;

  logic       clk = 1'b0;
  logic       nrst;
  logic       ena, msb_first, cpol, cpha;
  logic [7:0] data_in, data_out;
  logic       tx_load, new_byte, frame_abort, busy;
  logic       spi_clk, spi_mosi, spi_miso, spi_miso_oe, spi_cs_n;

  always #5 clk = ~clk;

  spi_target_physical #(.SYNC_STAGES(2)) dut (
    .clk(clk), .nrst(nrst), .ena(ena), .msb_first(msb_first), .cpol(cpol), .cpha(cpha),
    .data_in(data_in), .tx_load(tx_load), .data_out(data_out), .new_byte(new_byte),
    .frame_abort(frame_abort), .busy(busy), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .spi_cs_n(spi_cs_n)
  );

  int n_cmp = 0;
  int n_err = 0;

  int         nb_cnt = 0, tl_cnt = 0, fa_cnt = 0, oe_cnt = 0;
  logic [7:0] nb_q[$];

  always @(negedge clk) begin
    if (new_byte) begin
      nb_cnt++;
      nb_q.push_back(data_out);
    end
    if (tx_load)     tl_cnt++;
    if (frame_abort) fa_cnt++;
    if (spi_miso_oe) oe_cnt++;
  end

  typedef struct {
    logic       cpol, cpha, msb;
    logic [7:0] mosi, din, exp_dout, exp_mrx, exp_seq;
  } vec_t;

  vec_t vecs[6];

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Master transfer: tx[7:0] is the first byte on the wire, tx[15:8] the second.
  task automatic spi_bits(input logic [15:0] tx, input int nbits, input bit raise_cs,
                          output logic [15:0] rx, output logic [7:0] seq);
    logic [3:0] bi;
    rx  = '0;
    seq = '0;
    spi_clk  = cpol;
    spi_cs_n = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nbits; i++) begin
      bi = 4'((i / 8) * 8 + (msb_first ? 7 - (i % 8) : (i % 8)));
      if (!cpha) begin
        spi_mosi = tx[bi];
        wait_clk(H);
        spi_clk = ~cpol;
        rx[bi]  = spi_miso;
        if (i < 8) seq[3'(7 - i)] = spi_miso;
        wait_clk(H);
        spi_clk = cpol;
      end else begin
        spi_clk  = ~cpol;
        spi_mosi = tx[bi];
        wait_clk(H);
        spi_clk = cpol;
        rx[bi]  = spi_miso;
        if (i < 8) seq[3'(7 - i)] = spi_miso;
        wait_clk(H);
      end
    end
    wait_clk(6);
    if (raise_cs) begin
      spi_cs_n = 1'b1;
      wait_clk(8);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] rx;
    logic [7:0]  seq;
    int nb0, tl0, fa0, oe0;

    vecs[0] = '{1'b0, 1'b0, 1'b1, 8'hE5, 8'h3C, 8'hE5, 8'h3C, 8'h3C};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 8'h96, 8'hA3, 8'h96, 8'hA3, 8'hC5};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 8'h0F, 8'hF0, 8'h0F, 8'hF0, 8'hF0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 8'h81, 8'h7E, 8'h81, 8'h7E, 8'h7E};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 8'h01, 8'h80, 8'h01, 8'h80, 8'h01};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00};

    nrst = 1'b0; ena = 1'b1; msb_first = 1'b1; cpol = 1'b0; cpha = 1'b0;
    data_in = 8'h00; spi_clk = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1;
    wait_clk(4);
    check("rst_data_out", int'(data_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_miso_oe", int'(spi_miso_oe), 0);
    check("rst_miso", int'(spi_miso), 0);
    check("rst_new_byte", int'(new_byte), 0);
    check("rst_tx_load", int'(tx_load), 0);
    check("rst_frame_abort", int'(frame_abort), 0);
    nrst = 1'b1;
    wait_clk(6);

    // Single-byte frames across modes and bit orders.
    for (int i = 0; i < 6; i++) begin
      cpol = vecs[i].cpol; cpha = vecs[i].cpha; msb_first = vecs[i].msb;
      data_in = vecs[i].din;
      spi_clk = cpol;
      wait_clk(4);
      nb0 = nb_cnt; tl0 = tl_cnt; fa0 = fa_cnt;
      spi_bits({8'h00, vecs[i].mosi}, 8, 1'b1, rx, seq);
      check($sformatf("v%0d_data_out", i), int'(data_out), int'(vecs[i].exp_dout));
      check($sformatf("v%0d_new_byte_cnt", i), nb_cnt - nb0, 1);
      check($sformatf("v%0d_tx_load_cnt", i), tl_cnt - tl0, 2);
      check($sformatf("v%0d_abort_cnt", i), fa_cnt - fa0, 0);
      check($sformatf("v%0d_master_rx", i), int'(rx[7:0]), int'(vecs[i].exp_mrx));
      check($sformatf("v%0d_miso_seq", i), int'(seq), int'(vecs[i].exp_seq));
      check($sformatf("v%0d_busy_after", i), int'(busy), 0);
    end

    // Two bytes in one frame, mode 1.
    cpol = 1'b0; cpha = 1'b1; msb_first = 1'b1; data_in = 8'h5C; spi_clk = 1'b0;
    wait_clk(4);
    nb0 = nb_cnt; tl0 = tl_cnt;
    spi_bits(16'h3412, 16, 1'b1, rx, seq);
    check("b2b_new_byte_cnt", nb_cnt - nb0, 2);
    if (nb_cnt - nb0 == 2) begin
      check("b2b_byte0", int'(nb_q[nb0]), 8'h12);
      check("b2b_byte1", int'(nb_q[nb0 + 1]), 8'h34);
    end
    check("b2b_tx_load_cnt", tl_cnt - tl0, 3);
    check("b2b_master_rx", int'(rx), 16'h5C5C);

    // Partial byte then CS rise: abort.
    cpol = 1'b0; cpha = 1'b0; msb_first = 1'b1; spi_clk = 1'b0;
    wait_clk(4);
    nb0 = nb_cnt; fa0 = fa_cnt;
    spi_bits(16'h00FF, 5, 1'b1, rx, seq);
    check("abort_cnt", fa_cnt - fa0, 1);
    check("abort_new_byte_cnt", nb_cnt - nb0, 0);
    check("abort_data_out", int'(data_out), 8'h34);
    check("abort_busy", int'(busy), 0);
    check("abort_miso_oe", int'(spi_miso_oe), 0);

    // Disabled target ignores the whole frame.
    ena = 1'b0;
    wait_clk(4);
    nb0 = nb_cnt; tl0 = tl_cnt; oe0 = oe_cnt;
    spi_bits(16'h00AA, 8, 1'b1, rx, seq);
    check("ena0_new_byte_cnt", nb_cnt - nb0, 0);
    check("ena0_tx_load_cnt", tl_cnt - tl0, 0);
    check("ena0_oe_cycles", oe_cnt - oe0, 0);
    check("ena0_data_out", int'(data_out), 8'h34);
    ena = 1'b1;

    // Reset mid-byte, then the in-flight frame must be ignored.
    data_in = 8'h3C;
    wait_clk(4);
    spi_bits(16'h00F0, 4, 1'b0, rx, seq);
    check("mid_busy", int'(busy), 1);
    check("mid_miso_oe", int'(spi_miso_oe), 1);
    nrst = 1'b0;
    wait_clk(2);
    check("mrst_data_out", int'(data_out), 0);
    check("mrst_busy", int'(busy), 0);
    check("mrst_miso_oe", int'(spi_miso_oe), 0);
    check("mrst_miso", int'(spi_miso), 0);
    check("mrst_new_byte", int'(new_byte), 0);
    nrst = 1'b1;
    wait_clk(4);
    nb0 = nb_cnt; tl0 = tl_cnt; fa0 = fa_cnt; oe0 = oe_cnt;
    spi_bits(16'h0077, 8, 1'b1, rx, seq);
    check("post_rst_new_byte_cnt", nb_cnt - nb0, 0);
    check("post_rst_tx_load_cnt", tl_cnt - tl0, 0);
    check("post_rst_abort_cnt", fa_cnt - fa0, 0);
    check("post_rst_oe_cycles", oe_cnt - oe0, 0);
    nb0 = nb_cnt;
    spi_bits(16'h005A, 8, 1'b1, rx, seq);
    check("recover_new_byte_cnt", nb_cnt - nb0, 1);
    check("recover_data_out", int'(data_out), 8'h5A);
    check("recover_master_rx", int'(rx[7:0]), 8'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
